// File: rtl/mem_access_unit_pkg.sv
// Shared types and widths for the memory access stage.
// Holds the FSM encoding, datapath widths and default wait limit.
package mem_access_unit_pkg;

    localparam int XLEN        = 64;
    localparam int REGW        = 5;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_unit_mem_wb.sv
// MEM/WB pipeline register: loads EX/MEM values, inserts a bubble, or holds.
// Ports: clk, reset, bubble_i, load_i, *_i data fields, wb_*_o registered outputs.
import mem_access_unit_pkg::*;

module mem_wb_reg (
    input  logic            clk,
    input  logic            reset,
    input  logic            bubble_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] readdata_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [REGW-1:0] rd_i,
    input  logic            regwrite_i,
    input  logic            memtoreg_i,
    output logic [XLEN-1:0] wb_readdata_o,
    output logic [XLEN-1:0] wb_alu_result_o,
    output logic [REGW-1:0] wb_rd_o,
    output logic            wb_regwrite_o,
    output logic            wb_memtoreg_o
);

    always_ff @(posedge clk) begin
        if (reset || bubble_i) begin
            wb_readdata_o   <= '0;
            wb_alu_result_o <= '0;
            wb_rd_o         <= '0;
            wb_regwrite_o   <= 1'b0;
            wb_memtoreg_o   <= 1'b0;
        end else if (load_i) begin
            wb_readdata_o   <= readdata_i;
            wb_alu_result_o <= alu_result_i;
            wb_rd_o         <= rd_i;
            wb_regwrite_o   <= regwrite_i;
            wb_memtoreg_o   <= memtoreg_i;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: drives a req/ack data-memory handshake with timeout,
// stalls upstream while busy, resolves branches and feeds the MEM/WB register.
// Ports: EX/MEM inputs and controls, dmem_* bus, stall/pcsrc/flush/branch_target,
// wb_* MEM/WB outputs and sticky bus_error.
import mem_access_unit_pkg::*;

module mem_access_unit #(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] Adderout,
    input  logic [XLEN-1:0] result_out_alu,
    input  logic [XLEN-1:0] writedata_out,
    input  logic            zero,
    input  logic [REGW-1:0] rd,
    input  logic            Branch,
    input  logic            Memread,
    input  logic            Memtoreg,
    input  logic            MemWrite,
    input  logic            Regwrite,
    input  logic            addermuxselect,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            stall,
    output logic            pcsrc,
    output logic            flush,
    output logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] wb_readdata,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [REGW-1:0] wb_rd,
    output logic            wb_regwrite,
    output logic            wb_memtoreg,
    output logic            bus_error
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e          state_q;
    logic [7:0]      cnt_q;
    logic [XLEN-1:0] load_q;
    logic            berr_q;

    logic access;
    logic in_idle;
    logic in_req;

    assign access  = Memread | MemWrite;
    assign in_idle = (state_q == ST_IDLE);
    assign in_req  = (state_q == ST_REQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            load_q  <= '0;
            berr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        state_q <= ST_REQ;
                        cnt_q   <= '0;
                    end
                end
                ST_REQ: begin
                    // ack wins over a coincident timeout
                    if (dmem_ack) begin
                        state_q <= ST_DONE;
                        if (!MemWrite) load_q <= dmem_rdata;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        load_q  <= '0;
                        berr_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall         = (in_idle & access) | in_req;
    assign dmem_req      = in_req;
    assign dmem_we       = MemWrite & in_req;
    assign dmem_addr     = result_out_alu;
    assign dmem_wdata    = writedata_out;
    assign pcsrc         = Branch & zero;
    assign flush         = pcsrc;
    assign branch_target = addermuxselect ? result_out_alu : Adderout;
    assign bus_error     = berr_q;

    // Bubble exactly while stalled; otherwise (idle no-access, or DONE) load.
    mem_wb_reg u_mem_wb (
        .clk             (clk),
        .reset           (reset),
        .bubble_i        (stall),
        .load_i          (~stall),
        .readdata_i      (load_q),
        .alu_result_i    (result_out_alu),
        .rd_i            (rd),
        .regwrite_i      (Regwrite),
        .memtoreg_i      (Memtoreg),
        .wb_readdata_o   (wb_readdata),
        .wb_alu_result_o (wb_alu_result),
        .wb_rd_o         (wb_rd),
        .wb_regwrite_o   (wb_regwrite),
        .wb_memtoreg_o   (wb_memtoreg)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a
// transaction-level model of stall/latency/data/error behaviour.
module tb_mem_access_unit;

    localparam int TO_A = 16;
    localparam int TO_B = 4;

    logic        clk = 1'b0;
    logic        reset, rst_b;
    logic [63:0] Adderout, alu, wdata, rdata;
    logic        zero, Branch, Memread, Memtoreg, MemWrite, Regwrite, sel;
    logic [4:0]  rd;
    logic        ack, ack_b;

    logic        req_a, we_a, stall_a, pcsrc_a, flush_a, wbrw_a, wbm_a, berr_a;
    logic [63:0] addr_a, wd_a, bt_a, wbr_a, wba_a;
    logic [4:0]  wbrd_a;
    logic        req_b, we_b, stall_b, pcsrc_b, flush_b, wbrw_b, wbm_b, berr_b;
    logic [63:0] addr_b, wd_b, bt_b, wbr_b, wba_b;
    logic [4:0]  wbrd_b;

    int errs = 0;
    int checks = 0;

    logic [63:0] m_load = '0;
    bit          m_berr = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO_A)) dut (
        .clk(clk), .reset(reset), .Adderout(Adderout),
        .result_out_alu(alu), .writedata_out(wdata), .zero(zero),
        .rd(rd), .Branch(Branch), .Memread(Memread),
        .Memtoreg(Memtoreg), .MemWrite(MemWrite), .Regwrite(Regwrite),
        .addermuxselect(sel), .dmem_req(req_a), .dmem_we(we_a),
        .dmem_addr(addr_a), .dmem_wdata(wd_a), .dmem_ack(ack),
        .dmem_rdata(rdata), .stall(stall_a), .pcsrc(pcsrc_a),
        .flush(flush_a), .branch_target(bt_a), .wb_readdata(wbr_a),
        .wb_alu_result(wba_a), .wb_rd(wbrd_a), .wb_regwrite(wbrw_a),
        .wb_memtoreg(wbm_a), .bus_error(berr_a)
    );

    mem_access_unit #(.TIMEOUT(TO_B)) dut_to (
        .clk(clk), .reset(rst_b), .Adderout(Adderout),
        .result_out_alu(alu), .writedata_out(wdata), .zero(zero),
        .rd(rd), .Branch(Branch), .Memread(Memread),
        .Memtoreg(Memtoreg), .MemWrite(MemWrite), .Regwrite(Regwrite),
        .addermuxselect(sel), .dmem_req(req_b), .dmem_we(we_b),
        .dmem_addr(addr_b), .dmem_wdata(wd_b), .dmem_ack(ack_b),
        .dmem_rdata(rdata), .stall(stall_b), .pcsrc(pcsrc_b),
        .flush(flush_b), .branch_target(bt_b), .wb_readdata(wbr_b),
        .wb_alu_result(wba_b), .wb_rd(wbrd_b), .wb_regwrite(wbrw_b),
        .wb_memtoreg(wbm_b), .bus_error(berr_b)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        Adderout = '0; alu = '0; wdata = '0; rd = '0; zero = 0;
        Branch = 0; Memread = 0; Memtoreg = 0; MemWrite = 0;
        Regwrite = 0; sel = 0; ack = 0; rdata = '0;
    endtask

    // One instruction presented at EX/MEM and held until the stage accepts it.
    // n = cycles after dmem_req rises before ack (n >= TO_A means never).
    task automatic exec(input logic [63:0] a, input logic [63:0] add,
                        input logic [63:0] wd, input logic [4:0] r,
                        input bit mr, input bit mw, input bit mtr,
                        input bit rw, input bit br, input bit z,
                        input bit s, input int n, input logic [63:0] rdv);
        bit          acc;
        bit          hit;
        int          reqc;
        logic [63:0] bt;
        alu = a; Adderout = add; wdata = wd; rd = r;
        Memread = mr; MemWrite = mw; Memtoreg = mtr; Regwrite = rw;
        Branch = br; zero = z; sel = s; ack = 0; rdata = rdv;
        acc = mr | mw;
        bt = s ? a : add;
        if (!acc) begin
            @(negedge clk);
            chk("stall_nm", 64'(stall_a), 64'(0));
            chk("req_nm", 64'(req_a), 64'(0));
            chk("pcsrc", 64'(pcsrc_a), 64'(br & z));
            chk("flush", 64'(flush_a), 64'(br & z));
            chk("btarget", bt_a, bt);
            @(posedge clk); #1;
        end else begin
            hit  = n < TO_A;
            reqc = hit ? n + 1 : TO_A;
            for (int k = 0; k < reqc + 2; k++) begin
                @(negedge clk);
                chk("stall", 64'(stall_a), 64'(k <= reqc));
                chk("req", 64'(req_a), 64'(k >= 1 && k <= reqc));
                if (k >= 1 && k <= reqc) begin
                    chk("we", 64'(we_a), 64'(mw));
                    chk("addr", addr_a, a);
                    chk("wdata", wd_a, wd);
                    ack = (k - 1 == n);
                end else begin
                    ack = 0;
                end
                if (k >= 1) begin
                    chk("bub_rw", 64'(wbrw_a), 64'(0));
                    chk("bub_alu", wba_a, 64'(0));
                end
                @(posedge clk); #1;
            end
            ack = 0;
            if (hit) begin
                if (!mw) m_load = rdv;
            end else begin
                m_load = '0;
                m_berr = 1'b1;
            end
            chk("wb_rdata", wbr_a, m_load);
        end
        chk("wb_alu", wba_a, a);
        chk("wb_rd", 64'(wbrd_a), 64'(r));
        chk("wb_rw", 64'(wbrw_a), 64'(rw));
        chk("wb_m2r", 64'(wbm_a), 64'(mtr));
        chk("berr", 64'(berr_a), 64'(m_berr));
    endtask

    initial begin
        idle_inputs();
        reset = 1; rst_b = 1; ack_b = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wbr", wbr_a, 64'(0));
        chk("rst_wba", wba_a, 64'(0));
        chk("rst_rd", 64'(wbrd_a), 64'(0));
        chk("rst_rw", 64'(wbrw_a), 64'(0));
        chk("rst_berr", 64'(berr_a), 64'(0));
        chk("rst_req", 64'(req_a), 64'(0));
        reset = 0;

        exec(64'h10, 0, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        exec(64'h100, 0, 0, 7, 1, 0, 1, 1, 0, 0, 0, 0, 64'hDEAD);
        exec(64'h200, 0, 64'h55, 0, 0, 1, 0, 0, 0, 0, 0, 4, 64'h77);
        exec(64'h300, 64'h40, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        exec(64'h300, 64'h40, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        exec(64'h400, 64'h40, 0, 2, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        exec(64'h500, 0, 0, 9, 1, 0, 1, 1, 0, 0, 0, TO_A - 1, 64'hA5);

        for (int i = 0; i < 50; i++) begin
            int          op;
            int          n;
            logic [63:0] a, add, wd, rdv;
            bit          rwv;
            op  = $urandom_range(0, 3);
            n   = $urandom_range(0, 20);
            a   = {$urandom, $urandom};
            add = {$urandom, $urandom};
            wd  = {$urandom, $urandom};
            rdv = {$urandom, $urandom};
            rwv = 1'($urandom_range(0, 1));
            unique case (op)
                0: exec(a, add, wd, 5'($urandom), 0, 0, 0, rwv,
                        1'($urandom), 1'($urandom), 1'($urandom), n, rdv);
                1: exec(a, add, wd, 5'($urandom), 1, 0, 1, 1,
                        1'($urandom), 1'($urandom), 1'($urandom), n, rdv);
                2: exec(a, add, wd, 5'($urandom), 0, 1, 0, 0,
                        1'($urandom), 1'($urandom), 1'($urandom), n, rdv);
                default: exec(a, add, wd, 5'($urandom), 1, 1, 0, 0,
                        1'($urandom), 1'($urandom), 1'($urandom), n, rdv);
            endcase
        end

        // Reset during the second REQ cycle aborts the access.
        idle_inputs();
        alu = 64'h200; Memread = 1; Memtoreg = 1; Regwrite = 1; rd = 3;
        repeat (2) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("abort_req2", 64'(req_a), 64'(1));
        reset = 1;
        idle_inputs();
        @(posedge clk); #1;
        reset = 0;
        m_load = '0;
        m_berr = 1'b0;
        chk("abort_req", 64'(req_a), 64'(0));
        chk("abort_stall", 64'(stall_a), 64'(0));
        chk("abort_rw", 64'(wbrw_a), 64'(0));
        chk("abort_berr", 64'(berr_a), 64'(0));
        ack = 1; rdata = 64'hBEEF;
        @(posedge clk); #1;
        ack = 0;
        @(posedge clk); #1;
        chk("late_ack_req", 64'(req_a), 64'(0));
        chk("late_ack_rd", wbr_a, 64'(0));

        // Timeout instance with the ack never asserted.
        reset = 1;
        rst_b = 1;
        idle_inputs();
        rdata = 64'h1234;
        @(posedge clk); #1;
        rst_b = 0;
        alu = 64'h600; Memread = 1; Memtoreg = 1; Regwrite = 1; rd = 4;
        for (int k = 0; k < TO_B + 2; k++) begin
            @(negedge clk);
            chk("to_req", 64'(req_b), 64'(k >= 1 && k <= TO_B));
            chk("to_stall", 64'(stall_b), 64'(k <= TO_B));
            @(posedge clk); #1;
        end
        chk("to_rdata", wbr_b, 64'(0));
        chk("to_rw", 64'(wbrw_b), 64'(1));
        chk("to_berr", 64'(berr_b), 64'(1));
        idle_inputs();
        repeat (3) begin
            @(posedge clk); #1;
            chk("to_sticky", 64'(berr_b), 64'(1));
        end
        rst_b = 1;
        @(posedge clk); #1;
        chk("to_clr", 64'(berr_b), 64'(0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
